// File: rtl/extended_to_affine.sv
// extended_to_affine: converts extended Edwards (X:Y:Z) to canonical affine (X/Z, Y/Z) over p = 2^255-19.
// Z^-1 is formed as Z^(p-2) by square-and-multiply on a single shared Montgomery multiplier.
`default_nettype none

module Montgomery #(
  parameter logic [254:0] P      = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED,
  parameter int           DIGITS = 51
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [254:0] i_a,
  input  logic [254:0] i_b,
  output logic [254:0] o_montgomery,
  output logic         o_finished
);
  localparam int ITERS = 255 / DIGITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic [254:0]  a_q, b_q;
  logic [256:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [256:0]  w_acc_nxt;
  logic [254:0]  w_res;

  // DIGITS radix-2 REDC steps per clock; acc stays below 2P throughout.
  always_comb begin : comb_step
    logic [257:0] s;
    s = {1'b0, acc_q};
    for (int i = 0; i < DIGITS; i++) begin
      s = s + (a_q[i] ? {3'b000, b_q} : 258'd0);
      if (s[0]) s = s + {3'b000, P};
      s = {1'b0, s[257:1]};
    end
    w_acc_nxt = s[256:0];
    w_res     = 255'((w_acc_nxt >= {2'b00, P}) ? w_acc_nxt - {2'b00, P} : w_acc_nxt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      o_montgomery <= '0;
      o_finished   <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      if (i_start) begin
        a_q    <= i_a;
        b_q    <= i_b;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= w_acc_nxt;
        a_q   <= a_q >> DIGITS;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
          busy_q       <= 1'b0;
          o_finished   <= 1'b1;
          o_montgomery <= w_res;
        end
      end
    end
  end
endmodule

module extended_to_affine #(
  parameter logic [254:0] P  = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED,
  parameter logic [254:0] R2 = 255'h169,
  parameter logic [254:0] R1 = 255'h13
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [254:0] i_x,
  input  logic [254:0] i_y,
  input  logic [254:0] i_z,
  output logic [254:0] o_x,
  output logic [254:0] o_y,
  output logic         o_invalid,
  output logic         o_busy,
  output logic         o_finished
);
  localparam logic [254:0] EXP = P - 255'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQR, S_MUL, S_XMUL, S_YMUL
  } state_t;

  function automatic logic [254:0] reduce(input logic [254:0] v);
    return (v >= P) ? v - P : v;
  endfunction

  state_t       state_q;
  logic [254:0] x_q, y_q, z_q, zm_q, acc_q, tx_q;
  logic [7:0]   b_q;
  logic         mstart_q;
  logic [254:0] w_ma, w_mb, w_mres, w_zr;
  logic         w_mdone;

  assign w_zr = reduce(i_z);

  // Operands follow the state, which only changes together with the start pulse.
  always_comb begin
    w_ma = acc_q;
    w_mb = acc_q;
    case (state_q)
      S_TOMONT: begin w_ma = z_q; w_mb = R2;   end
      S_MUL:    begin w_ma = acc_q; w_mb = zm_q; end
      S_XMUL:   begin w_ma = x_q; w_mb = acc_q; end
      S_YMUL:   begin w_ma = y_q; w_mb = acc_q; end
      default:  begin w_ma = acc_q; w_mb = acc_q; end
    endcase
  end

  Montgomery #(.P(P)) u_mont (
    .i_clk        (i_clk),
    .i_rst        (!i_rst_n),
    .i_start      (mstart_q),
    .i_a          (w_ma),
    .i_b          (w_mb),
    .o_montgomery (w_mres),
    .o_finished   (w_mdone)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      zm_q       <= '0;
      acc_q      <= '0;
      tx_q       <= '0;
      b_q        <= '0;
      mstart_q   <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_invalid  <= 1'b0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
    end else begin
      mstart_q   <= 1'b0;
      o_finished <= 1'b0;
      case (state_q)
        S_IDLE: if (i_start) begin
          x_q   <= reduce(i_x);
          y_q   <= reduce(i_y);
          z_q   <= w_zr;
          acc_q <= R1;
          if (w_zr == '0) begin
            o_x        <= '0;
            o_y        <= '0;
            o_invalid  <= 1'b1;
            o_finished <= 1'b1;
          end else begin
            state_q  <= S_TOMONT;
            mstart_q <= 1'b1;
            o_busy   <= 1'b1;
          end
        end
        S_TOMONT: if (w_mdone) begin
          zm_q     <= w_mres;
          acc_q    <= w_mres;
          b_q      <= 8'd253;
          state_q  <= S_SQR;
          mstart_q <= 1'b1;
        end
        S_SQR: if (w_mdone) begin
          acc_q    <= w_mres;
          mstart_q <= 1'b1;
          if (EXP[b_q])        state_q <= S_MUL;
          else if (b_q == '0)  state_q <= S_XMUL;
          else                 b_q     <= b_q - 8'd1;
        end
        S_MUL: if (w_mdone) begin
          acc_q    <= w_mres;
          mstart_q <= 1'b1;
          if (b_q == '0) state_q <= S_XMUL;
          else begin
            b_q     <= b_q - 8'd1;
            state_q <= S_SQR;
          end
        end
        S_XMUL: if (w_mdone) begin
          tx_q     <= w_mres;
          mstart_q <= 1'b1;
          state_q  <= S_YMUL;
        end
        // Completion is committed on the edge that captures the last product.
        S_YMUL: if (w_mdone) begin
          o_x        <= reduce(tx_q);
          o_y        <= reduce(w_mres);
          o_invalid  <= 1'b0;
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
